hamming_enc_sched: RTL and testbench

Round-robin scheduler that shares one serial 4-bit Hamming(7,4) encoder among `NREQ` requesters. It accepts a nibble from the winning requester and serialises it into the encoder LSB-first. It then captures the 7-bit codeword and returns it with the requester ID over a valid/ready response port. It sits between the nibble producers and the single encoder instance and owns that encoder's `start`/`din` inputs.

---
 rtl/hamming_pkg.sv | 33 +++
 rtl/hamming_rr_pick.sv | 43 ++++
 rtl/hamming_enc_sched.sv | 156 +++++++++++++++
 tb/tb_hamming_enc_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(7,4) encoder scheduler.
// Serial data order: nibble bit 0 is sent first.
// Codeword layout: {d3,d2,d1,d0,p2,p1,p0}.
package hamming_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    localparam int unsigned HAM_DATA_W   = 4;
    localparam int unsigned HAM_CODE_W   = 7;
    localparam int unsigned HAM_PAR_W    = HAM_CODE_W - HAM_DATA_W;
    // Data bits sit above the parity bits in the codeword.
    localparam int unsigned HAM_DATA_LSB = HAM_PAR_W;
    localparam int unsigned HAM_P0_POS   = 0;
    localparam int unsigned HAM_P1_POS   = 1;
    localparam int unsigned HAM_P2_POS   = 2;

    // Reference encoder for benches; the scheduler never computes parity itself.
    function automatic logic [HAM_CODE_W-1:0] hamming74_encode(input logic [HAM_DATA_W-1:0] d);
        logic [HAM_CODE_W-1:0] c;
        c = '0;
        c[HAM_DATA_LSB +: HAM_DATA_W] = d;
        c[HAM_P0_POS] = d[0] ^ d[1] ^ d[2];
        c[HAM_P1_POS] = d[0] ^ d[2] ^ d[3];
        c[HAM_P2_POS] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

endpackage

// File: rtl/hamming_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so that the
// pointer position is bit 0, take the lowest set bit, then map back.
module hamming_rr_pick
    import hamming_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IDW-1:0]    w_k;
    logic              w_found;
    logic [IDW:0]      w_sum;

    // Rotate, priority-encode the lowest requester, unrotate modulo NREQ.
    always_comb begin
        w_dbl   = {valid, valid} >> ptr;
        w_rot   = w_dbl[NREQ-1:0];
        w_k     = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_rot[k] && !w_found) begin
                w_found = 1'b1;
                w_k     = IDW'(k);
            end
        end
        w_sum = {1'b0, ptr} + {1'b0, w_k};
        if (w_sum >= (IDW+1)'(NREQ)) begin
            w_sum = w_sum - (IDW+1)'(NREQ);
        end
        any          = |valid;
        grant_idx    = any ? w_sum[IDW-1:0] : '0;
        grant_onehot = any ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
    end

endmodule

// File: rtl/hamming_enc_sched.sv
// Round-robin scheduler sharing one serial Hamming(7,4) encoder among NREQ
// requesters. One transaction in flight: grant, shift 4 bits LSB-first,
// wait for the codeword (with timeout), then hold it on a valid/ready port.
module hamming_enc_sched
    import hamming_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 8,
    localparam int unsigned IDW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [4*NREQ-1:0]     req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  enc_ready,
    output logic                  enc_start,
    output logic                  enc_din,
    input  logic                  enc_done,
    input  logic [HAM_CODE_W-1:0] enc_dout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [HAM_CODE_W-1:0] rsp_code,
    output logic                  err_timeout
);

    localparam logic [3:0] WLIM = 4'(TIMEOUT - 1);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [IDW-1:0]        r_ptr;
    logic [IDW-1:0]        r_id;
    logic [IDW-1:0]        r_rsp_id;
    logic [1:0]            r_cnt;
    logic [3:0]            r_wcnt;
    logic [HAM_DATA_W-1:0] r_nib;
    logic [HAM_CODE_W-1:0] r_rsp_code;
    logic                  r_err;

    logic [NREQ-1:0]       w_grant_oh;
    logic [IDW-1:0]        w_grant_idx;
    logic                  w_any;
    logic                  w_grant;
    logic [IDW-1:0]        w_ptr_nxt;

    hamming_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid        (req_valid),
        .ptr          (r_ptr),
        .grant_onehot (w_grant_oh),
        .grant_idx    (w_grant_idx),
        .any          (w_any)
    );

    assign w_grant     = (r_state == ST_IDLE) && enc_ready && w_any && !rst;
    assign w_ptr_nxt   = (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
    assign rsp_id      = r_rsp_id;
    assign rsp_code    = r_rsp_code;
    assign err_timeout = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake/encoder outputs.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        enc_start   = 1'b0;
        enc_din     = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    req_ready   = w_grant_oh;
                    enc_start   = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                enc_din = r_nib[r_cnt];
                if (r_cnt == 2'd3) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // done takes priority over an expiring wait counter
                if (enc_done) begin
                    w_state_nxt = ST_RESP;
                end else if (r_wcnt == WLIM) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch nibble/id, bit and wait counters, response capture, timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_id       <= '0;
            r_rsp_id   <= '0;
            r_cnt      <= '0;
            r_wcnt     <= '0;
            r_nib      <= '0;
            r_rsp_code <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_nib <= req_data[{w_grant_idx, 2'b00} +: HAM_DATA_W];
                        r_id  <= w_grant_idx;
                        r_ptr <= w_ptr_nxt;
                        r_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_wcnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (enc_done) begin
                        r_rsp_code <= enc_dout;
                        r_rsp_id   <= r_id;
                    end else if (r_wcnt == WLIM) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_enc_sched.sv
// Bench for hamming_enc_sched with a behavioural serial encoder model.
module tb_hamming_enc_sched;
    import hamming_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        enc_ready;
    logic        enc_start;
    logic        enc_din;
    logic        enc_done;
    logic [6:0]  enc_dout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [6:0]  rsp_code;
    logic        err_timeout;

    int n_checks = 0;
    int n_errors = 0;
    int ptr_m    = 0;

    // encoder model state
    int         e_ph    = 0;
    int         e_dl    = 0;
    int         e_delay = 0;
    bit         e_never = 1'b0;
    bit         tb_hold = 1'b0;
    logic [3:0] e_sh    = 4'h0;

    hamming_enc_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .enc_ready   (enc_ready),
        .enc_start   (enc_start),
        .enc_din     (enc_din),
        .enc_done    (enc_done),
        .enc_dout    (enc_dout),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_code    (rsp_code),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Serial encoder: 4 bits after start, done e_delay cycles after the last bit.
    assign enc_ready = (e_ph == 0) && !tb_hold;
    assign enc_done  = (e_ph == 5) && (e_dl == e_delay) && !e_never;
    assign enc_dout  = enc_done ? hamming74_encode(e_sh) : 7'h55;

    always @(posedge clk) begin
        if (rst) begin
            e_ph <= 0;
            e_dl <= 0;
        end else begin
            case (e_ph)
                0: if (enc_start) e_ph <= 1;
                1, 2, 3, 4: begin
                    e_sh[2'(e_ph - 1)] <= enc_din;
                    e_ph <= e_ph + 1;
                    e_dl <= 0;
                end
                default: begin
                    if (e_dl >= e_delay) e_ph <= 0;
                    else e_dl <= e_dl + 1;
                end
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Round-robin reference: first valid requester at or after ptr, wrapping.
    function automatic int ref_pick(input logic [3:0] m, input int p);
        for (int off = 0; off < NREQ; off++) begin
            if (((m >> ((p + off) % NREQ)) & 4'd1) != 4'd0) return (p + off) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [6:0] ref_code(input logic [3:0] d);
        return {d, d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[2]};
    endfunction

    // One full transaction starting at the grant cycle (caller is just past a posedge).
    task automatic txn(input logic [3:0] mask, input logic [15:0] data, input int hold,
                       input int delay, input bit never);
        int         win;
        logic [3:0] nib;
        bit         to;
        req_valid = mask;
        req_data  = data;
        rsp_ready = (hold == 0);
        e_delay   = delay;
        e_never   = never;
        win = ref_pick(mask, ptr_m);
        nib = 4'(data >> (4 * win));
        smp();
        chk("grant_req_ready", 32'(req_ready), 32'(4'b0001 << win));
        chk("grant_enc_start", 32'(enc_start), 32'd1);
        chk("grant_rsp_valid", 32'(rsp_valid), 32'd0);
        ptr_m = (win + 1) % NREQ;
        for (int k = 0; k < 4; k++) begin
            nxt();
            if (k == 0) begin
                req_valid = mask & ~(4'b0001 << win);
                req_data  = data ^ (16'h000F << (4 * win));
            end
            smp();
            chk("shift_din", 32'(enc_din), 32'((nib >> k) & 4'd1));
            chk("shift_start", 32'(enc_start), 32'd0);
            chk("shift_req_ready", 32'(req_ready), 32'd0);
        end
        to = never || (delay >= TIMEOUT);
        if (!to) begin
            for (int w = 0; w <= delay; w++) begin
                nxt();
                smp();
                chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("wait_err", 32'(err_timeout), 32'd0);
                chk("wait_din", 32'(enc_din), 32'd0);
            end
            for (int h = 0; h <= hold; h++) begin
                nxt();
                rsp_ready = (h == hold);
                smp();
                chk("rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_code", 32'(rsp_code), 32'(ref_code(nib)));
                chk("rsp_id", 32'(rsp_id), 32'(win));
                chk("rsp_no_grant", 32'(req_ready), 32'd0);
                chk("rsp_no_start", 32'(enc_start), 32'd0);
                chk("rsp_err", 32'(err_timeout), 32'd0);
            end
        end else begin
            for (int w = 0; w < TIMEOUT; w++) begin
                nxt();
                smp();
                chk("to_wait_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("to_wait_err", 32'(err_timeout), 32'd0);
            end
            nxt();
            req_valid = '0;
            smp();
            chk("to_err_pulse", 32'(err_timeout), 32'd1);
            chk("to_rsp_valid", 32'(rsp_valid), 32'd0);
            nxt();
            smp();
            chk("to_err_once", 32'(err_timeout), 32'd0);
            chk("to_no_rsp", 32'(rsp_valid), 32'd0);
        end
        nxt();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_enc_start"}, 32'(enc_start), 32'd0);
        chk({tag, "_enc_din"}, 32'(enc_din), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_code"}, 32'(rsp_code), 32'd0);
        chk({tag, "_err"}, 32'(err_timeout), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) nxt();
        rst = 1'b0;
        smp();
        chk_reset_outputs("reset");
        nxt();

        // all four requesters at once: 0,1,2,3 seven cycles apart
        txn(4'b1111, 16'hB6F1, 0, 0, 0);
        txn(4'b1110, 16'hB6F1, 0, 0, 0);
        txn(4'b1100, 16'hB6F1, 0, 0, 0);
        txn(4'b1000, 16'hB6F1, 0, 0, 0);

        // single requester 0 with nibble 1011
        txn(4'b0001, 16'h000B, 0, 0, 0);

        // response back-pressure for 5 cycles with pending requests
        txn(4'b1111, 16'($urandom), 5, 0, 0);
        txn(4'b1111, 16'($urandom), 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 16; i++) begin
            txn(4'($urandom_range(1, 15)), 16'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 3), 0);
        end

        // done on the last wait cycle wins over the timeout
        txn(4'($urandom_range(1, 15)), 16'($urandom), 0, TIMEOUT - 1, 0);
        // encoder never answers
        txn(4'($urandom_range(1, 15)), 16'($urandom), 0, 0, 1);
        txn(4'($urandom_range(1, 15)), 16'($urandom), 1, 0, 0);
        // done one cycle too late is ignored
        txn(4'($urandom_range(1, 15)), 16'($urandom), 0, TIMEOUT, 0);
        txn(4'($urandom_range(1, 15)), 16'($urandom), 0, 1, 0);

        // encoder busy: requests wait
        tb_hold   = 1'b1;
        req_valid = 4'b0101;
        req_data  = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_enc_start", 32'(enc_start), 32'd0);
            nxt();
        end
        tb_hold = 1'b0;
        txn(4'b0101, 16'($urandom), 0, 0, 0);

        // reset in the middle of a transaction
        req_valid = 4'b0010;
        req_data  = 16'($urandom);
        e_delay   = 0;
        e_never   = 1'b0;
        smp();
        chk("rst_txn_grant", 32'(req_ready), 32'b0010);
        nxt();
        req_valid = '0;
        nxt();
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        ptr_m = 0;
        smp();
        chk_reset_outputs("midrst");
        nxt();
        txn(4'b1111, 16'($urandom), 0, 0, 0);

        // pointer example: ptr=2 with 1011 grants 3, 0, 1
        txn(4'b0010, 16'($urandom), 0, 0, 0);
        txn(4'b1011, 16'($urandom), 0, 0, 0);
        txn(4'b1011, 16'($urandom), 0, 0, 0);
        txn(4'b1011, 16'($urandom), 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
